// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO block.
// Holds the FIFO geometry, the CPU register offsets, STATUS/CTRL bit positions,
// the capture FSM state encodings, the CTRL field layout and the interrupt
// threshold helper.
package uart_rx_fifo_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  // CPU word offsets (addr[3:2])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // STATUS bit positions (count occupies [AW:0])
  localparam int ST_EMPTY_BIT = 8;
  localparam int ST_FULL_BIT  = 9;
  localparam int ST_OVR_BIT   = 10;

  // CTRL bit positions (threshold occupies [AW-1:0])
  localparam int CTRL_IRQ_EN_BIT     = 8;
  localparam int CTRL_OVR_IRQ_EN_BIT = 9;
  localparam int CTRL_FLUSH_BIT      = 31;

  // Capture FSM encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  typedef struct packed {
    logic          ovr_irq_en;
    logic          irq_en;
    logic [AW-1:0] threshold;
  } ctrl_t;

  // A threshold of 0 behaves as 1 so an empty FIFO never raises the data interrupt.
  function automatic logic [AW:0] eff_threshold(input logic [AW-1:0] thr);
    return (thr == {AW{1'b0}}) ? {{AW{1'b0}}, 1'b1} : {1'b0, thr};
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receive FIFO and its surroundings.
// Carries the receiver-core handshake (rx_data/rx_ready/rx_clear) and the CPU
// register window (en/Wen/addr/wdata/rd_data/interrupt).
// master: the environment (receiver core + CPU); slave: the FIFO block.
interface uart_rx_fifo_if;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        rx_clear;
  logic        en;
  logic        Wen;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        interrupt;

  modport master (
    output rx_data, rx_ready, en, Wen, addr, wdata,
    input  rx_clear, rd_data, interrupt
  );

  modport slave (
    input  rx_data, rx_ready, en, Wen, addr, wdata,
    output rx_clear, rd_data, interrupt
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// DEPTH x 8 circular byte buffer with push, pop and flush.
// Ports: clk, reset (async active-low); push_i/wdata_i write the tail,
// pop_i advances the head, flush_i empties the buffer (wins over push/pop);
// rdata_o is the current head byte, count_o/full_o/empty_o give occupancy.
import uart_rx_fifo_pkg::*;

module uart_fifo_mem (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW-1:0] PTR_ONE    = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o    = (count_q == FULL_COUNT);
  assign empty_o   = (count_q == {(AW+1){1'b0}});
  assign rdata_o   = mem_q[head_q];
  assign count_o   = count_q;
  // Full is judged before any same-cycle pop, so a push into a full buffer is always lost.
  assign push_ok_s = push_i & ~full_o & ~flush_i;
  assign pop_ok_s  = pop_i & ~empty_o & ~flush_i;

  // Next-state pointers and occupancy.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_d = tail_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_ok_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= {AW{1'b0}};
      tail_q  <= {AW{1'b0}};
      count_q <= {(AW+1){1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Byte storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[tail_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: drains the receiver core's holding register into a
// 16-entry FIFO and exposes it as a CPU register window.
// Ports: clk, reset (async active-low), bus (uart_rx_fifo_if.slave) carrying
// rx_data/rx_ready/rx_clear to the core and en/Wen/addr/wdata/rd_data/interrupt
// to the CPU. Registers: 0 DATA (pop), 1 STATUS, 2 CTRL, 3 reserved.
import uart_rx_fifo_pkg::*;

module uart_rx_fifo (
  input  logic           clk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  logic [1:0]  state_q, state_d;
  logic        rx_clear_q;
  logic [31:0] rd_data_q, rd_data_d;
  logic        overrun_q, overrun_d;
  ctrl_t       ctrl_q, ctrl_d;

  logic        rd_s, wr_s, flush_s, capture_s, push_s, pop_s, ovr_set_s;
  logic [7:0]  head_s;
  logic [AW:0] count_s;
  logic        full_s, empty_s;
  logic [31:0] status_s, ctrl_word_s;
  logic        unused_wdata_s;

  assign rd_s      = bus.en & ~bus.Wen;
  assign wr_s      = bus.en & bus.Wen;
  assign flush_s   = wr_s & (bus.addr == REG_CTRL) & bus.wdata[CTRL_FLUSH_BIT];
  assign capture_s = (state_q == S_IDLE) & bus.rx_ready;
  // A flush in the same cycle swallows the byte without flagging an overrun.
  assign push_s    = capture_s & ~full_s & ~flush_s;
  assign ovr_set_s = capture_s & full_s;
  assign pop_s     = rd_s & (bus.addr == REG_DATA) & ~empty_s;

  assign unused_wdata_s = ^{bus.wdata[30:11], bus.wdata[7:AW]};

  uart_fifo_mem u_mem (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .wdata_i (bus.rx_data),
    .rdata_o (head_s),
    .count_o (count_s),
    .full_o  (full_s),
    .empty_o (empty_s)
  );

  // Capture FSM: WAIT holds off until the core's flag has fallen to avoid a double push.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rx_ready) begin
          state_d = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: state_d = S_WAIT;
      S_WAIT: begin
        if (!bus.rx_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Read-back views of STATUS and CTRL (pre-update values).
  always_comb begin
    status_s                  = 32'h0;
    status_s[AW:0]            = count_s;
    status_s[ST_EMPTY_BIT]    = empty_s;
    status_s[ST_FULL_BIT]     = full_s;
    status_s[ST_OVR_BIT]      = overrun_q;
    ctrl_word_s                      = 32'h0;
    ctrl_word_s[AW-1:0]              = ctrl_q.threshold;
    ctrl_word_s[CTRL_IRQ_EN_BIT]     = ctrl_q.irq_en;
    ctrl_word_s[CTRL_OVR_IRQ_EN_BIT] = ctrl_q.ovr_irq_en;
  end

  // Read data mux; rd_data holds between read accesses.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_s) begin
      case (bus.addr)
        REG_DATA:   rd_data_d = empty_s ? 32'h0 : {24'h0, head_s};
        REG_STATUS: rd_data_d = status_s;
        REG_CTRL:   rd_data_d = ctrl_word_s;
        default:    rd_data_d = 32'h0;
      endcase
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Sticky overrun (set beats a same-cycle W1C) and CTRL writes.
  always_comb begin
    overrun_d = overrun_q;
    ctrl_d    = ctrl_q;
    if (wr_s && (bus.addr == REG_STATUS) && bus.wdata[ST_OVR_BIT]) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end
    if (wr_s && (bus.addr == REG_CTRL)) begin
      ctrl_d.threshold  = bus.wdata[AW-1:0];
      ctrl_d.irq_en     = bus.wdata[CTRL_IRQ_EN_BIT];
      ctrl_d.ovr_irq_en = bus.wdata[CTRL_OVR_IRQ_EN_BIT];
    end else begin
      ctrl_d = ctrl_q;
    end
  end

  // Block state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rx_clear_q <= 1'b0;
      rd_data_q  <= 32'h0;
      overrun_q  <= 1'b0;
      ctrl_q     <= '{ovr_irq_en: 1'b0, irq_en: 1'b0, threshold: {{(AW-1){1'b0}}, 1'b1}};
    end else begin
      state_q    <= state_d;
      rx_clear_q <= (state_d == S_CLEAR);
      rd_data_q  <= rd_data_d;
      overrun_q  <= overrun_d;
      ctrl_q     <= ctrl_d;
    end
  end

  assign bus.rx_clear  = rx_clear_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.interrupt = (ctrl_q.irq_en & (count_s >= eff_threshold(ctrl_q.threshold)))
                       | (ctrl_q.ovr_irq_en & overrun_q);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver core. It drains each completed byte from the receiver's single-byte holding register (rx_data/rx_ready, acknowledged with rx_clear) into a 16-entry FIFO. It exposes the FIFO to the CPU as a small memory-mapped register window with a status register and a level-triggered interrupt. Single-byte receive overruns in the core become buffered bursts the CPU can drain at its own pace.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2
- AW, 4, log2(DEPTH)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from receiver core, valid while rx_ready=1
- rx_ready  in  1  receiver holds a complete byte; level, stays high until cleared
- rx_clear  out  1  one-cycle pulse acknowledging/consuming the held byte
- en  in  1  CPU select for this window
- Wen  in  1  CPU write strobe, qualified by en
- addr  in  2  word offset (CPU addr[3:2])
- wdata  in  32  CPU write data
- rd_data  out  32  registered read data
- interrupt  out  1  level interrupt to CPU

## Operation
- Register map (word offset):
  - 0 DATA: read pops head byte into rd_data[7:0] (upper bits 0); writes ignored.
  - 1 STATUS: [AW:0] count, [8] empty, [9] full, [10] overrun (sticky); writing 1 to bit 10 clears overrun.
  - 2 CTRL: [AW-1:0] threshold, [8] irq_en, [9] ovr_irq_en, [31] flush (self-clearing, reads 0).
  - 3 reserved: reads 0, writes ignored.
- Capture FSM: IDLE, CLEAR, WAIT.
  - IDLE with rx_ready=1: push rx_data if not full; if full, drop byte and set overrun. Go to CLEAR.
  - CLEAR: rx_clear=1 for exactly this cycle. Go to WAIT.
  - WAIT: stay until rx_ready=0, then go to IDLE. This prevents a double push while the core's flag falls.
- FIFO: circular buffer; head/tail pointers AW bits and wrap naturally; count AW+1 bits, 0..DEPTH.
- Pop:
  - Occurs on en & ~Wen & addr==0 & ~empty.
  - DATA read when empty returns 0, does not pop, and leaves pointers and overrun unchanged.
- Simultaneous push and pop in the same cycle: both take effect and count is unchanged.
  - Push when full: always dropped, even if a pop occurs the same cycle (full is evaluated pre-pop).
- Flush: resets pointers and count to 0. Does not clear overrun, does not disturb the capture FSM.
  - If a push coincides with flush, flush wins and the byte is lost without setting overrun.
- interrupt = (irq_en & count ≥ max(threshold,1)) | (ovr_irq_en & overrun). Purely combinational from registers.

## Timing
- Reset values:
  - Outputs: rx_clear=0, rd_data=0, interrupt=0.
  - State: FSM=IDLE, count=0, pointers=0, overrun=0.
  - CTRL: threshold=1, irq_en=0, ovr_irq_en=0.
- Capture latency:
  - Cycle N: rx_ready seen in IDLE.
  - Edge N+1: count/STATUS updated; rx_clear high during cycle N+1.
  - Core drops rx_ready at edge N+2.
  - The FSM is back in IDLE no earlier than cycle N+3.
- Read latency: rd_data valid one cycle after the en & ~Wen access and holds until the next read access.
  - STATUS read reflects state before any same-cycle push/pop.
- Write: register update on the edge ending the en & Wen cycle.
  - Same-cycle capture of an overrun and a W1C to bit 10: set wins.
- Reset asserted mid-capture: FSM returns to IDLE and rx_clear drops immediately.
  - If the core still holds rx_ready after reset release, the byte is captured normally.

## Structure
- Shared package (macros header): register offsets, STATUS/CTRL bit positions, FSM state encodings, DEPTH default.
- One sub-module: uart_fifo_mem (DEPTH×8 storage with push/pop/flush, pointers, count, full/empty).
  - The top level holds the capture FSM, register decode, rd_data register and interrupt logic.

## Test plan
- Single byte: core presents 0x5A with rx_ready → rx_clear single pulse at N+1, STATUS count=1; DATA read → rd_data=0x0000005A next cycle, count=0, empty=1.
- Fill and overrun: push 17 bytes 0x00..0x10 with no reads → full=1, count=16, overrun=1. Byte 0x10 dropped, reads return 0x00..0x0F in order, then reads return 0. Index wrap exercised.
- Simultaneous push and pop at count=5 → count stays 5, ordering preserved.
  - Repeat at count=16: incoming byte dropped, overrun=1, count=15.
- Interrupt: threshold=4, irq_en=1 → interrupt rises on the edge count becomes 4 and falls after a pop to 3.
  - ovr_irq_en=1 plus overrun → interrupt high until W1C of STATUS bit 10.
- Flush and reset: write CTRL bit 31 with 7 bytes queued → count=0, overrun unchanged.
  - Assert reset while in CLEAR → rx_clear=0 and all outputs 0 immediately, asynchronously.
- rx_ready held high 10 cycles by a stalled core → exactly one push and one rx_clear pulse.
